// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, reads instruction memory over req/ack and feeds
// the decoder through an output slot backed by a one-entry skid buffer.
// Optional macro FETCH_COUNT_EN adds a 32-bit count of instructions delivered.
module instruction_fetch #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]      NOP_WORD = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instruct,
  output logic              instruct_valid,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    SKID  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_W-1:0] req_addr, req_addr_next;
  logic [15:0]       slot_word, slot_word_next;
  logic [ADDR_W-1:0] slot_pc, slot_pc_next;
  logic              slot_valid, slot_valid_next;
  logic [15:0]       skid_word, skid_word_next;
  logic [ADDR_W-1:0] skid_pc, skid_pc_next;
  logic              skid_full, skid_full_next;

  logic              slot_free;
  logic [ADDR_W-1:0] addr_inc;

  assign slot_free = !slot_valid || !stall;
  assign addr_inc  = req_addr + ADDR_W'(1);

  assign mem_req        = (state == FETCH) || (state == DROP);
  assign mem_addr       = req_addr;
  assign instruct       = slot_valid ? slot_word : NOP_WORD;
  assign instruct_valid = slot_valid;
  assign pc             = slot_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      slot_word  <= NOP_WORD;
      slot_pc    <= '0;
      slot_valid <= 1'b0;
      skid_word  <= NOP_WORD;
      skid_pc    <= '0;
      skid_full  <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      req_addr   <= req_addr_next;
      slot_word  <= slot_word_next;
      slot_pc    <= slot_pc_next;
      slot_valid <= slot_valid_next;
      skid_word  <= skid_word_next;
      skid_pc    <= skid_pc_next;
      skid_full  <= skid_full_next;
    end
  end

  // Redirect is checked first in every state so it beats both ack and stall.
  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    req_addr_next   = req_addr;
    slot_word_next  = slot_word;
    slot_pc_next    = slot_pc;
    slot_valid_next = slot_valid && stall;
    skid_word_next  = skid_word;
    skid_pc_next    = skid_pc;
    skid_full_next  = skid_full;

    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect_valid) begin
          slot_valid_next = 1'b0;
          fetch_pc_next   = redirect_pc;
          req_addr_next   = redirect_pc;
        end else begin
          req_addr_next = fetch_pc;
        end
      end

      FETCH: begin
        if (redirect_valid) begin
          slot_valid_next = 1'b0;
          fetch_pc_next   = redirect_pc;
          if (mem_ack) begin
            req_addr_next = redirect_pc;
          end else begin
            state_next = DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_next = addr_inc;
          if (slot_free) begin
            slot_word_next  = mem_data;
            slot_pc_next    = req_addr;
            slot_valid_next = 1'b1;
            req_addr_next   = addr_inc;
          end else begin
            skid_word_next = mem_data;
            skid_pc_next   = req_addr;
            skid_full_next = 1'b1;
            state_next     = SKID;
          end
        end
      end

      // The stale request must complete before the new address can be issued.
      DROP: begin
        if (redirect_valid) begin
          slot_valid_next = 1'b0;
          fetch_pc_next   = redirect_pc;
        end
        if (mem_ack) begin
          req_addr_next = redirect_valid ? redirect_pc : fetch_pc;
          state_next    = FETCH;
        end
      end

      SKID: begin
        if (redirect_valid) begin
          slot_valid_next = 1'b0;
          skid_full_next  = 1'b0;
          fetch_pc_next   = redirect_pc;
          req_addr_next   = redirect_pc;
          state_next      = FETCH;
        end else if (!stall) begin
          slot_word_next  = skid_word;
          slot_pc_next    = skid_pc;
          slot_valid_next = 1'b1;
          skid_full_next  = 1'b0;
          req_addr_next   = fetch_pc;
          state_next      = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef FETCH_COUNT_EN
  logic count_inc;

  // Only loads into the output slot count; discarded words never reach it.
  assign count_inc = !redirect_valid &&
                     (((state == FETCH) && mem_ack && slot_free) ||
                      ((state == SKID) && !stall));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (count_inc) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, skid stall, redirects,
// asynchronous reset and address wrap, against hand-computed values.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instruct;
  logic        instruct_valid;
  logic [15:0] pc;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int compared;
  int mismatched;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instruct       (instruct),
    .instruct_valid (instruct_valid),
    .pc             (pc)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  // Memory image: word at address a is a + 16'h1000.
  assign mem_data = mem_addr + 16'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_slot(input string tag, input logic valid_exp,
                            input logic [15:0] pc_exp, input logic [15:0] instr_exp);
    check_output({tag, "_valid"}, 32'(instruct_valid), 32'(valid_exp));
    check_output({tag, "_pc"}, 32'(pc), 32'(pc_exp));
    check_output({tag, "_instr"}, 32'(instruct), 32'(instr_exp));
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    mem_ack        = 1'b1;

    #2;
    check_output("rst_req", 32'(mem_req), 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'h0000);
    check_slot("rst", 1'b0, 16'h0000, 16'h0800);

    @(posedge clk);
    #1 rst = 1'b1;
    check_output("idle_req", 32'(mem_req), 32'd0);

    // Streaming with ack tied high
    tick();
    check_output("f0_req", 32'(mem_req), 32'd1);
    check_output("f0_addr", 32'(mem_addr), 32'h0000);
    check_output("f0_valid", 32'(instruct_valid), 32'd0);
    tick();
    check_slot("s0", 1'b1, 16'h0000, 16'h1000);
    check_output("s0_addr", 32'(mem_addr), 32'h0001);
    tick();
    check_slot("s1", 1'b1, 16'h0001, 16'h1001);
    check_output("s1_addr", 32'(mem_addr), 32'h0002);
    tick();
    check_slot("s2", 1'b1, 16'h0002, 16'h1002);
    tick();
    check_slot("s3", 1'b1, 16'h0003, 16'h1003);
    tick();
    check_slot("s4", 1'b1, 16'h0004, 16'h1004);
    check_output("s4_addr", 32'(mem_addr), 32'h0005);

    // Stall for three edges while addr 5 is acked into the skid
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("stall", 1'b1, 16'h0004, 16'h1004);
      check_output("stall_req", 32'(mem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    check_slot("unstall5", 1'b1, 16'h0005, 16'h1005);
    check_output("unstall5_req", 32'(mem_req), 32'd1);
    check_output("unstall5_addr", 32'(mem_addr), 32'h0006);
    tick();
    check_slot("unstall6", 1'b1, 16'h0006, 16'h1006);
    check_output("unstall6_addr", 32'(mem_addr), 32'h0007);

    // Redirect to 0x0010 while addr 7 is outstanding
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    mem_ack        = 1'b0;
    tick();
    check_slot("drop7", 1'b0, 16'h0006, 16'h0800);
    check_output("drop7_addr", 32'(mem_addr), 32'h0007);
    redirect_valid = 1'b0;
    mem_ack        = 1'b1;
    tick();
    check_output("after_drop_addr", 32'(mem_addr), 32'h0010);
    check_output("after_drop_valid", 32'(instruct_valid), 32'd0);

    // Redirect to 0x0040 while 0x0010 is outstanding; ack two cycles later
    mem_ack        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    check_output("redir40_addr", 32'(mem_addr), 32'h0010);
    check_output("redir40_req", 32'(mem_req), 32'd1);
    redirect_valid = 1'b0;
    tick();
    check_output("wait_ack_addr", 32'(mem_addr), 32'h0010);
    check_output("wait_ack_valid", 32'(instruct_valid), 32'd0);
    mem_ack = 1'b1;
    tick();
    check_output("req40_addr", 32'(mem_addr), 32'h0040);
    check_output("req40_valid", 32'(instruct_valid), 32'd0);
    tick();
    check_slot("got40", 1'b1, 16'h0040, 16'h1040);
    check_output("got40_addr", 32'(mem_addr), 32'h0041);

    // Redirect together with ack and stall
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    tick();
    check_output("rak_valid", 32'(instruct_valid), 32'd0);
    check_output("rak_addr", 32'(mem_addr), 32'h0080);
    check_output("rak_req", 32'(mem_req), 32'd1);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check_slot("got80", 1'b1, 16'h0080, 16'h1080);

    // Redirect out of SKID flushes the skid entry
    stall = 1'b1;
    tick();
    check_output("skid81_req", 32'(mem_req), 32'd0);
    check_slot("skid81", 1'b1, 16'h0080, 16'h1080);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h00A0;
    tick();
    check_output("skidredir_valid", 32'(instruct_valid), 32'd0);
    check_output("skidredir_addr", 32'(mem_addr), 32'h00A0);
    check_output("skidredir_req", 32'(mem_req), 32'd1);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();
    check_slot("gotA0", 1'b1, 16'h00A0, 16'h10A0);

    // Address wrap at 0xFFFF
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    check_output("wrap_req_addr", 32'(mem_addr), 32'hFFFE);
    tick();
    check_slot("gotFFFE", 1'b1, 16'hFFFE, 16'h0FFE);
    tick();
    check_slot("gotFFFF", 1'b1, 16'hFFFF, 16'h0FFF);
    check_output("wrap_addr", 32'(mem_addr), 32'h0000);
    tick();
    check_slot("got0000", 1'b1, 16'h0000, 16'h1000);

    // Asynchronous reset mid-FETCH at 0x0123
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0122;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_slot("got122", 1'b1, 16'h0122, 16'h1122);
    check_output("pre_rst_addr", 32'(mem_addr), 32'h0123);
    mem_ack = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_output("arst_req", 32'(mem_req), 32'd0);
    check_slot("arst", 1'b0, 16'h0000, 16'h0800);
    @(posedge clk);
    #1 rst = 1'b1;
    mem_ack = 1'b1;
    tick();
    check_output("restart_addr", 32'(mem_addr), 32'h0000);
    check_output("restart_req", 32'(mem_req), 32'd1);
    tick();
    check_slot("restart0", 1'b1, 16'h0000, 16'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the fetch PC and issues 16-bit word reads to instruction memory over a req/ack handshake.
- Presents one instruction plus its PC per cycle to the decoder.
- Absorbs decoder stalls with a one-entry skid buffer and handles PC redirects from branch/jump resolution, discarding in-flight fetches.

Parameters:
- ADDR_W, 16, instruction memory word-address width.
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_WORD, 16'h0800, value driven on instruct while invalid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  ADDR_W  read word address; stable while mem_req=1.
- mem_ack  in  1  read complete this cycle; mem_data valid.
- mem_data  in  16  instruction word returned.
- stall  in  1  decoder cannot accept; hold instruct.
- redirect_valid  in  1  load new PC; flush fetch.
- redirect_pc  in  ADDR_W  redirect target.
- instruct  out  16  instruction to decoder.
- instruct_valid  out  1  instruct/pc meaningful.
- pc  out  ADDR_W  address of instruct.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, mem_req=0.
  - instruct=NOP_WORD, instruct_valid=0, pc=0, skid empty.
  - Deassertion mid-transaction abandons it; memory must tolerate a dropped req.
- Registers: fetch_pc (next address to request), req_addr (address of outstanding request), output slot (instruct/pc/valid), skid (word+pc).
- mem_addr = req_addr. Address increment is +1 (word addressing), wrapping modulo 2^ADDR_W.
- Output slot is "free" when instruct_valid=0 or stall=0 this cycle.
- When instruct_valid=1 and stall=0, the slot is consumed at the clock edge; instruct_valid clears unless it is reloaded in the same edge.
- IDLE:
  - mem_req=0.
  - Next edge: req_addr=fetch_pc, mem_req=1, go FETCH.
  - Redirect in IDLE: fetch_pc=redirect_pc first.
- FETCH (mem_req=1):
  - mem_ack & !redirect & slot free: load slot (instruct=mem_data, pc=req_addr, valid=1), fetch_pc=req_addr+1, req_addr=req_addr+1, stay FETCH. Gives back-to-back, 1 instr/cycle with a single-cycle ack.
  - mem_ack & !redirect & slot not free: load skid, fetch_pc=req_addr+1, mem_req=0, go SKID.
  - redirect & !mem_ack: instruct_valid=0, fetch_pc=redirect_pc, go DROP (request stays outstanding, mem_addr unchanged).
  - redirect & mem_ack: data discarded, instruct_valid=0, req_addr=fetch_pc=redirect_pc, stay FETCH.
- DROP (mem_req=1, old address):
  - mem_ack: discard data; req_addr=fetch_pc; go FETCH.
  - Further redirect: overwrite fetch_pc; data still discarded.
- SKID (mem_req=0, slot valid, skid full):
  - stall=0: slot=skid, skid empty, req_addr=fetch_pc, mem_req=1, go FETCH.
  - redirect: clear slot and skid, fetch_pc=req_addr=redirect_pc, mem_req=1, go FETCH.
- Redirect has priority over stall and ack; instruct_valid=0 the cycle after any redirect.
- No instruction is ever duplicated or lost without a redirect.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Extra output port fetch_count (out, 32): increments by 1 each edge an instruction is loaded into the output slot (directly or from skid).
  - Discarded fetches are not counted. Wraps at 2^32. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release with mem_ack tied 1, stall=0 → mem_addr 0,1,2,…; instruct_valid=1 from 3rd cycle with pc=0,1,2 and instruct = memory contents.
- Stall held 3 cycles while ack returns addr 5 → instruct/pc frozen at addr 4, addr 5 held in skid, mem_req=0; on stall release pc=5 then pc=6 with no gap or duplicate.
- Redirect to 16'h0040 while request to 16'h0010 outstanding (ack 2 cycles later) → mem_addr stays 16'h0010 until ack, that data discarded, next request 16'h0040, first valid pc=16'h0040.
- Redirect in the same cycle as ack and stall=1 → instruct_valid=0 next cycle, skid empty, next mem_addr=redirect_pc.
- rst pulsed low mid-FETCH at req_addr 16'h0123 → immediately mem_req=0, instruct=16'h0800, instruct_valid=0; after release fetch restarts at RESET_PC.
- Fetch at 16'hFFFF with ADDR_W=16 → next request 16'h0000.
